clic_irq_arbiter: RTL

- Interrupt arbiter and sequencer between the platform's interrupt sources and the core's CLIC-style interrupt port (one-hot request, 8-bit level, SHV bit, ack).
- Latches edge-triggered sources and filters them by enable and the level threshold.
- Selects one winner, presents it to the core, and holds it stable until the core acknowledges or the request is withdrawn.
- Sits beside the core in the top-level wrapper and drives the core's irq_i / irq_level_i / irq_shv_i, consuming its irq_ack_o.

---
 rtl/clic_irq_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/clic_irq_arbiter.sv
// CLIC-style interrupt arbiter and sequencer.
// Latches edge sources and filters all sources by enable and level threshold.
// Picks one winner: highest level first, then the highest index on a tie.
// Presents the winner to the core and holds it until the core acks it or the
// request goes away.
// rst_i asserts asynchronously. The wrapper is expected to release it
// synchronously to clk_i.
module clic_irq_arbiter #(
    parameter int NumSrc     = 256,
    parameter int LevelWidth = 8,
    parameter int IdWidth    = $clog2(NumSrc)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumSrc-1:0]            irq_src_i,
    input  logic [NumSrc-1:0]            irq_en_i,
    input  logic [NumSrc-1:0]            irq_trig_edge_i,
    input  logic [NumSrc-1:0]            irq_shv_cfg_i,
    input  logic [NumSrc*LevelWidth-1:0] irq_level_cfg_i,
    input  logic [LevelWidth-1:0]        irq_thresh_i,
    output logic [NumSrc-1:0]            irq_o,
    output logic [LevelWidth-1:0]        irq_level_o,
    output logic                         irq_shv_o,
    output logic [IdWidth-1:0]           irq_id_o,
    input  logic                         irq_ack_i,
    output logic [NumSrc-1:0]            irq_clear_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    state_t state_r, state_s;

    // Edge-detection history. armed_r masks the first cycle after reset, so a
    // line that is already high at reset release is not taken as a new edge.
    logic [NumSrc-1:0] src_prev_r;
    logic [NumSrc-1:0] trig_prev_r;
    logic              armed_r;
    logic [NumSrc-1:0] edge_pend_r;
    logic [NumSrc-1:0] edge_pend_s;

    logic [NumSrc-1:0] rise_s;
    logic [NumSrc-1:0] trig_chg_s;
    logic [NumSrc-1:0] pend_s;
    logic [NumSrc-1:0] elig_s;
    logic [NumSrc-1:0] clr_s;

    logic                  any_elig_s;
    logic [IdWidth-1:0]    win_id_s;
    logic [LevelWidth-1:0] win_level_s;
    logic                  win_shv_s;

    logic [NumSrc-1:0]     irq_s;
    logic [LevelWidth-1:0] level_s;
    logic                  shv_s;
    logic [IdWidth-1:0]    id_s;
    logic [NumSrc-1:0]     clear_s;

    // One-hot vector with a single bit set at idx.
    function automatic logic [NumSrc-1:0] onehot(input logic [IdWidth-1:0] idx);
        logic [NumSrc-1:0] v;
        v      = {NumSrc{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Compute the pending vector and the next state of the edge latches.
    // A new edge overrides a clear that lands in the same cycle.
    always_comb begin
        rise_s      = armed_r ? (irq_src_i & ~src_prev_r) : {NumSrc{1'b0}};
        trig_chg_s  = armed_r ? (irq_trig_edge_i ^ trig_prev_r) : {NumSrc{1'b0}};
        clr_s       = ((state_r == ST_REQ) && irq_ack_i) ? onehot(irq_id_o) : {NumSrc{1'b0}};
        edge_pend_s = ((edge_pend_r & ~clr_s) | rise_s) & irq_trig_edge_i & ~trig_chg_s;
        pend_s      = (((edge_pend_r | rise_s) & ~trig_chg_s) & irq_trig_edge_i)
                    | (irq_src_i & ~irq_trig_edge_i);
    end

    // Per-source eligibility: pending, enabled, and level strictly above threshold.
    always_comb begin
        elig_s = {NumSrc{1'b0}};
        for (int k = 0; k < NumSrc; k++) begin
            elig_s[k] = pend_s[k] & irq_en_i[k]
                      & (irq_level_cfg_i[k*LevelWidth +: LevelWidth] > irq_thresh_i);
        end
    end

    // Linear priority scan. Using >= lets a later (higher) index win a level tie.
    always_comb begin
        any_elig_s  = 1'b0;
        win_id_s    = {IdWidth{1'b0}};
        win_level_s = {LevelWidth{1'b0}};
        win_shv_s   = 1'b0;
        for (int k = 0; k < NumSrc; k++) begin
            logic upd;
            upd = elig_s[k] & (~any_elig_s
                  | (irq_level_cfg_i[k*LevelWidth +: LevelWidth] >= win_level_s));
            any_elig_s  = any_elig_s | upd;
            win_id_s    = upd ? IdWidth'(k) : win_id_s;
            win_level_s = upd ? irq_level_cfg_i[k*LevelWidth +: LevelWidth] : win_level_s;
            win_shv_s   = upd ? irq_shv_cfg_i[k] : win_shv_s;
        end
    end

    // Sequencer next state and next registered outputs.
    // Outputs hold their value by default; leaving REQ zeroes them all.
    always_comb begin
        state_s = state_r;
        irq_s   = irq_o;
        level_s = irq_level_o;
        shv_s   = irq_shv_o;
        id_s    = irq_id_o;
        clear_s = {NumSrc{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (any_elig_s) begin
                    irq_s   = onehot(win_id_s);
                    level_s = win_level_s;
                    shv_s   = win_shv_s;
                    id_s    = win_id_s;
                    state_s = ST_REQ;
                end else begin
                    irq_s   = {NumSrc{1'b0}};
                    level_s = {LevelWidth{1'b0}};
                    shv_s   = 1'b0;
                    id_s    = {IdWidth{1'b0}};
                end
            end
            ST_REQ: begin
                if (irq_ack_i) begin
                    // Ack takes priority over a withdrawal in the same cycle.
                    clear_s = clr_s & irq_trig_edge_i;
                    irq_s   = {NumSrc{1'b0}};
                    level_s = {LevelWidth{1'b0}};
                    shv_s   = 1'b0;
                    id_s    = {IdWidth{1'b0}};
                    state_s = ST_COOL;
                end else if (!elig_s[irq_id_o]) begin
                    irq_s   = {NumSrc{1'b0}};
                    level_s = {LevelWidth{1'b0}};
                    shv_s   = 1'b0;
                    id_s    = {IdWidth{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_COOL: begin
                irq_s   = {NumSrc{1'b0}};
                level_s = {LevelWidth{1'b0}};
                shv_s   = 1'b0;
                id_s    = {IdWidth{1'b0}};
                state_s = ST_IDLE;
            end
            default: begin
                irq_s   = {NumSrc{1'b0}};
                level_s = {LevelWidth{1'b0}};
                shv_s   = 1'b0;
                id_s    = {IdWidth{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // Edge-detection history and edge latches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_prev_r  <= {NumSrc{1'b0}};
            trig_prev_r <= {NumSrc{1'b0}};
            armed_r     <= 1'b0;
            edge_pend_r <= {NumSrc{1'b0}};
        end else begin
            src_prev_r  <= irq_src_i;
            trig_prev_r <= irq_trig_edge_i;
            armed_r     <= 1'b1;
            edge_pend_r <= edge_pend_s;
        end
    end

    // Sequencer state and registered core-facing outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            irq_o       <= {NumSrc{1'b0}};
            irq_level_o <= {LevelWidth{1'b0}};
            irq_shv_o   <= 1'b0;
            irq_id_o    <= {IdWidth{1'b0}};
            irq_clear_o <= {NumSrc{1'b0}};
        end else begin
            state_r     <= state_s;
            irq_o       <= irq_s;
            irq_level_o <= level_s;
            irq_shv_o   <= shv_s;
            irq_id_o    <= id_s;
            irq_clear_o <= clear_s;
        end
    end

endmodule
